// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared types and widths for the data-memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, READ_WAIT)
//   arb_owner_t : which requester owns the current/last access
//   STARVE_W    : width of the debug starvation counter
//   LAT_W       : width of the read-latency down-counter (latency 1..4)
package dmem_arb_pkg;

    typedef enum logic {
        IDLE,
        READ_WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_CORE,
        OWN_DBG
    } arb_owner_t;

    localparam int STARVE_W = 4;
    localparam int LAT_W    = 2;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick
// Combinational winner selection between the core and the debug requester.
// Core has fixed priority unless the debug port has been passed over
// STARVE_LIMIT consecutive times, in which case debug wins once.
// Ports:
//   core_req, dbg_req : pending requests
//   starve_cnt        : consecutive core grants while debug was waiting
//   any_req           : at least one requester is asking
//   winner            : requester that would be granted this cycle
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                core_req,
    input  logic                dbg_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                any_req,
    output arb_owner_t          winner
);

    // Debug only beats a simultaneous core request once it has starved
    // for the full limit; alone it always wins.
    always_comb begin
        any_req = core_req | dbg_req;
        winner  = OWN_CORE;
        if (dbg_req && (!core_req || (starve_cnt == STARVE_W'(STARVE_LIMIT)))) begin
            winner = OWN_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-requester (core, debug/loader) arbiter in front of a single-port data
// memory with a fixed read latency. One access outstanding at a time.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   core_req/we/addr/wdata/funct3      : core request fields
//   core_gnt, core_rvalid, core_rdata  : core grant pulse, read return
//   dbg_*                              : same set for the debug requester
//   mem_wren, mem_address, mem_data_in,
//   mem_funct3                         : memory command (held between grants)
//   mem_data_out                       : memory read data
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [2:0]  core_funct3,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic [2:0]  dbg_funct3,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        mem_wren,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_data_out
);

    arb_state_t          state, next_state;
    arb_owner_t          owner, winner;
    logic [LAT_W-1:0]    lat_cnt;
    logic [STARVE_W-1:0] starve_cnt;
    logic                any_req;
    logic                read_done;
    logic                grant;
    logic                win_we;
    logic [31:0]         win_addr, win_wdata;
    logic [2:0]          win_funct3;
    logic [31:0]         addr_q, wdata_q;
    logic [2:0]          funct3_q;
    logic [31:0]         core_rdata_q, dbg_rdata_q;

    dmem_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .core_req  (core_req),
        .dbg_req   (dbg_req),
        .starve_cnt(starve_cnt),
        .any_req   (any_req),
        .winner    (winner)
    );

    // Route the winning requester's fields toward the memory command.
    always_comb begin
        win_we     = core_we;
        win_addr   = core_addr;
        win_wdata  = core_wdata;
        win_funct3 = core_funct3;
        if (winner == OWN_DBG) begin
            win_we     = dbg_we;
            win_addr   = dbg_addr;
            win_wdata  = dbg_wdata;
            win_funct3 = dbg_funct3;
        end
    end

    // Next-state and pulse outputs. The last READ_WAIT cycle (counter at
    // zero) both returns the read data and may accept the next request.
    // Reset suppresses every pulse so it wins over a simultaneous request
    // and kills a read that would have returned in that cycle.
    always_comb begin
        next_state  = state;
        read_done   = (state == READ_WAIT) && (lat_cnt == '0);
        grant       = !reset && any_req && ((state == IDLE) || read_done);
        core_gnt    = grant && (winner == OWN_CORE);
        dbg_gnt     = grant && (winner == OWN_DBG);
        mem_wren    = grant && win_we;
        core_rvalid = !reset && read_done && (owner == OWN_CORE);
        dbg_rvalid  = !reset && read_done && (owner == OWN_DBG);
        if (state == IDLE) begin
            if (grant && !win_we) next_state = READ_WAIT;
        end else begin
            if (read_done) next_state = (grant && !win_we) ? READ_WAIT : IDLE;
        end
    end

    // Memory command is live during a grant and otherwise replays the last
    // granted values; read data passes straight through while valid.
    always_comb begin
        mem_address = grant ? win_addr   : addr_q;
        mem_data_in = grant ? win_wdata  : wdata_q;
        mem_funct3  = grant ? win_funct3 : funct3_q;
        core_rdata  = core_rvalid ? mem_data_out : core_rdata_q;
        dbg_rdata   = dbg_rvalid  ? mem_data_out : dbg_rdata_q;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath registers: held command, owner, latency and starvation
    // counters, and the last returned read word for each requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner        <= OWN_CORE;
            lat_cnt      <= '0;
            starve_cnt   <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            funct3_q     <= '0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            if (grant) begin
                owner    <= winner;
                addr_q   <= win_addr;
                wdata_q  <= win_wdata;
                funct3_q <= win_funct3;
            end
            if (grant && !win_we) begin
                lat_cnt <= LAT_W'(READ_LATENCY - 1);
            end else if ((state == READ_WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (!dbg_req || (grant && (winner == OWN_DBG))) begin
                starve_cnt <= '0;
            end else if (grant) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
            if (core_rvalid) core_rdata_q <= mem_data_out;
            if (dbg_rvalid)  dbg_rdata_q  <= mem_data_out;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Scoreboard bench for dmem_arbiter. Instance 0 uses READ_LATENCY=1,
// instance 1 uses READ_LATENCY=3; both STARVE_LIMIT=4. Directed stimulus
// pushes hand-computed expected events; a negedge monitor pops and compares
// whenever an instance shows a grant, rvalid or write enable.
module tb_dmem_arbiter;

    typedef struct {
        int          cyc;
        logic        cg;
        logic        dg;
        logic        cr;
        logic        dr;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset       [2];
    logic        core_req    [2];
    logic        core_we     [2];
    logic [31:0] core_addr   [2];
    logic [31:0] core_wdata  [2];
    logic [2:0]  core_funct3 [2];
    logic        core_gnt    [2];
    logic        core_rvalid [2];
    logic [31:0] core_rdata  [2];
    logic        dbg_req     [2];
    logic        dbg_we      [2];
    logic [31:0] dbg_addr    [2];
    logic [31:0] dbg_wdata   [2];
    logic [2:0]  dbg_funct3  [2];
    logic        dbg_gnt     [2];
    logic        dbg_rvalid  [2];
    logic [31:0] dbg_rdata   [2];
    logic        mem_wren    [2];
    logic [31:0] mem_address [2];
    logic [31:0] mem_data_in [2];
    logic [2:0]  mem_funct3  [2];
    logic [31:0] mem_data_out[2];

    logic [31:0] mem  [2][256];
    logic        vld  [2][256];
    logic [31:0] pipe [2][4];

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   c;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(4)) u_dut0 (
        .clk(clk), .reset(reset[0]),
        .core_req(core_req[0]), .core_we(core_we[0]), .core_addr(core_addr[0]),
        .core_wdata(core_wdata[0]), .core_funct3(core_funct3[0]),
        .core_gnt(core_gnt[0]), .core_rvalid(core_rvalid[0]), .core_rdata(core_rdata[0]),
        .dbg_req(dbg_req[0]), .dbg_we(dbg_we[0]), .dbg_addr(dbg_addr[0]),
        .dbg_wdata(dbg_wdata[0]), .dbg_funct3(dbg_funct3[0]),
        .dbg_gnt(dbg_gnt[0]), .dbg_rvalid(dbg_rvalid[0]), .dbg_rdata(dbg_rdata[0]),
        .mem_wren(mem_wren[0]), .mem_address(mem_address[0]), .mem_data_in(mem_data_in[0]),
        .mem_funct3(mem_funct3[0]), .mem_data_out(mem_data_out[0])
    );

    dmem_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(4)) u_dut1 (
        .clk(clk), .reset(reset[1]),
        .core_req(core_req[1]), .core_we(core_we[1]), .core_addr(core_addr[1]),
        .core_wdata(core_wdata[1]), .core_funct3(core_funct3[1]),
        .core_gnt(core_gnt[1]), .core_rvalid(core_rvalid[1]), .core_rdata(core_rdata[1]),
        .dbg_req(dbg_req[1]), .dbg_we(dbg_we[1]), .dbg_addr(dbg_addr[1]),
        .dbg_wdata(dbg_wdata[1]), .dbg_funct3(dbg_funct3[1]),
        .dbg_gnt(dbg_gnt[1]), .dbg_rvalid(dbg_rvalid[1]), .dbg_rdata(dbg_rdata[1]),
        .mem_wren(mem_wren[1]), .mem_address(mem_address[1]), .mem_data_in(mem_data_in[1]),
        .mem_funct3(mem_funct3[1]), .mem_data_out(mem_data_out[1])
    );

    // Memory model: unwritten words read as 0xC0DE0000 | byte address;
    // read data emerges READ_LATENCY cycles after the grant cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset[i]) begin
                for (int k = 0; k < 256; k++) vld[i][k] <= 1'b0;
            end else if (mem_wren[i]) begin
                mem[i][mem_address[i][9:2]] <= mem_data_in[i];
                vld[i][mem_address[i][9:2]] <= 1'b1;
            end
            if ((core_gnt[i] || dbg_gnt[i]) && !mem_wren[i]) begin
                pipe[i][0] <= vld[i][mem_address[i][9:2]] ? mem[i][mem_address[i][9:2]]
                                                          : (32'hC0DE0000 | {22'h0, mem_address[i][9:0]});
            end else begin
                pipe[i][0] <= 32'h0;
            end
            for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
        end
    end

    assign mem_data_out[0] = pipe[0][0];
    assign mem_data_out[1] = pipe[1][2];

    task automatic expectEvent(input int i, input int ecyc, input logic cg, input logic dg,
                               input logic cr, input logic dr, input logic we,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [2:0] f3, input logic [31:0] rd);
        exp_t e;
        e.cyc = ecyc; e.cg = cg; e.dg = dg; e.cr = cr; e.dr = dr; e.we = we;
        e.addr = addr; e.wd = wd; e.f3 = f3; e.rd = rd;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic applyStimulus(input int i, input logic creq, input logic cwe,
                                 input logic [31:0] caddr, input logic [31:0] cwd,
                                 input logic dreq, input logic dwe,
                                 input logic [31:0] daddr, input logic [31:0] dwd);
        core_req[i] = creq; core_we[i] = cwe; core_addr[i] = caddr; core_wdata[i] = cwd;
        dbg_req[i]  = dreq; dbg_we[i]  = dwe; dbg_addr[i]  = daddr; dbg_wdata[i]  = dwd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int i);
        exp_t e;
        bit   ok;
        bit   empty;
        if (!(core_gnt[i] || dbg_gnt[i] || core_rvalid[i] || dbg_rvalid[i] || mem_wren[i])) return;
        checks++;
        empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
            errors++;
            $display("[TB] FAIL inst%0d unexpected_event cyc=%0d got cg=%b dg=%b cr=%b dr=%b we=%b required no event",
                     i, cyc, core_gnt[i], dbg_gnt[i], core_rvalid[i], dbg_rvalid[i], mem_wren[i]);
            return;
        end
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        ok = (e.cyc == cyc) && (core_gnt[i] === e.cg) && (dbg_gnt[i] === e.dg) &&
             (core_rvalid[i] === e.cr) && (dbg_rvalid[i] === e.dr) &&
             (mem_wren[i] === e.we) && (mem_address[i] === e.addr);
        if (e.cg || e.dg) ok = ok && (mem_data_in[i] === e.wd) && (mem_funct3[i] === e.f3);
        if (e.cr) ok = ok && (core_rdata[i] === e.rd);
        if (e.dr) ok = ok && (dbg_rdata[i] === e.rd);
        if (!ok) begin
            errors++;
            $display("[TB] FAIL inst%0d event got cyc=%0d cg=%b dg=%b cr=%b dr=%b we=%b addr=%h wd=%h f3=%b crd=%h drd=%h required cyc=%0d cg=%b dg=%b cr=%b dr=%b we=%b addr=%h wd=%h f3=%b rd=%h",
                     i, cyc, core_gnt[i], dbg_gnt[i], core_rvalid[i], dbg_rvalid[i], mem_wren[i],
                     mem_address[i], mem_data_in[i], mem_funct3[i], core_rdata[i], dbg_rdata[i],
                     e.cyc, e.cg, e.dg, e.cr, e.dr, e.we, e.addr, e.wd, e.f3, e.rd);
        end
    endtask

    task automatic checkResetState(input int i, input string name);
        logic [3:0] sc;
        sc = (i == 0) ? u_dut0.starve_cnt : u_dut1.starve_cnt;
        checks++;
        if (core_gnt[i] !== 1'b0 || dbg_gnt[i] !== 1'b0 || core_rvalid[i] !== 1'b0 ||
            dbg_rvalid[i] !== 1'b0 || mem_wren[i] !== 1'b0 || mem_address[i] !== 32'h0 ||
            mem_data_in[i] !== 32'h0 || mem_funct3[i] !== 3'h0 || core_rdata[i] !== 32'h0 ||
            dbg_rdata[i] !== 32'h0 || sc !== 4'h0) begin
            errors++;
            $display("[TB] FAIL inst%0d %s got gnt=%b%b rv=%b%b we=%b addr=%h wd=%h f3=%b crd=%h drd=%h starve=%0d required all zero",
                     i, name, core_gnt[i], dbg_gnt[i], core_rvalid[i], dbg_rvalid[i], mem_wren[i],
                     mem_address[i], mem_data_in[i], mem_funct3[i], core_rdata[i], dbg_rdata[i], sc);
        end
    endtask

    // Monitor: compare every presented event against the scoreboard.
    always @(negedge clk) begin
        checkOutput(0);
        checkOutput(1);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1;
            core_req[i] = 1'b0; core_we[i] = 1'b0; core_addr[i] = '0; core_wdata[i] = '0;
            dbg_req[i]  = 1'b0; dbg_we[i]  = 1'b0; dbg_addr[i]  = '0; dbg_wdata[i]  = '0;
            core_funct3[i] = 3'b010;
            dbg_funct3[i]  = 3'b100;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetState(0, "reset_state");
        checkResetState(1, "reset_state");
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        @(posedge clk);
        #1;

        // Core write 0x100 then read it back (latency 1).
        c = cyc;
        expectEvent(0, c,   1, 0, 0, 0, 1, 32'h100, 32'hDEADBEEF, 3'b010, 32'h0);
        applyStimulus(0, 1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
        expectEvent(0, c+1, 1, 0, 0, 0, 0, 32'h100, 32'h0, 3'b010, 32'h0);
        applyStimulus(0, 1, 0, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0);
        expectEvent(0, c+2, 0, 0, 1, 0, 0, 32'h100, 32'h0, 3'b000, 32'hDEADBEEF);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);

        // Back-to-back core reads 0x0, 0x4.
        c = cyc;
        expectEvent(0, c,   1, 0, 0, 0, 0, 32'h0, 32'h0, 3'b010, 32'h0);
        applyStimulus(0, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        expectEvent(0, c+1, 1, 0, 1, 0, 0, 32'h4, 32'h0, 3'b010, 32'hC0DE0000);
        applyStimulus(0, 1, 0, 32'h4, 32'h0, 0, 0, 32'h0, 32'h0);
        expectEvent(0, c+2, 0, 0, 1, 0, 0, 32'h4, 32'h0, 3'b000, 32'hC0DE0004);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);

        // Both requesters writing continuously: C,C,C,C,D,C,C,C,C,D.
        c = cyc;
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9)
                expectEvent(0, c+k, 0, 1, 0, 0, 1, 32'h300, 32'h22222222, 3'b100, 32'h0);
            else
                expectEvent(0, c+k, 1, 0, 0, 0, 1, 32'h200, 32'h11111111, 3'b010, 32'h0);
            applyStimulus(0, 1, 1, 32'h200, 32'h11111111, 1, 1, 32'h300, 32'h22222222);
        end
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);

        // dbg_req drops for one cycle after 3 core grants: count restarts.
        c = cyc;
        for (int k = 0; k < 9; k++) begin
            if (k == 8)
                expectEvent(0, c+k, 0, 1, 0, 0, 1, 32'h300, 32'h22222222, 3'b100, 32'h0);
            else
                expectEvent(0, c+k, 1, 0, 0, 0, 1, 32'h200, 32'h11111111, 3'b010, 32'h0);
            applyStimulus(0, 1, 1, 32'h200, 32'h11111111, (k != 3), 1, 32'h300, 32'h22222222);
        end
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);

        // Latency 3: dbg read at T, core waits until T+3.
        c = cyc;
        expectEvent(1, c,   0, 1, 0, 0, 0, 32'h8, 32'h0, 3'b100, 32'h0);
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h8, 32'h0);
        expectEvent(1, c+3, 1, 0, 0, 1, 0, 32'hC, 32'h0, 3'b010, 32'hC0DE0008);
        for (int k = 0; k < 3; k++) applyStimulus(1, 1, 0, 32'hC, 32'h0, 0, 0, 32'h0, 32'h0);
        expectEvent(1, c+6, 0, 0, 1, 0, 0, 32'hC, 32'h0, 3'b000, 32'hC0DE000C);
        for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);

        // Build starvation count, grant a read, then reset the cycle after.
        c = cyc;
        expectEvent(1, c,   1, 0, 0, 0, 1, 32'h20, 32'h33, 3'b010, 32'h0);
        applyStimulus(1, 1, 1, 32'h20, 32'h33, 1, 1, 32'h30, 32'h44);
        expectEvent(1, c+1, 1, 0, 0, 0, 1, 32'h20, 32'h33, 3'b010, 32'h0);
        applyStimulus(1, 1, 1, 32'h20, 32'h33, 1, 1, 32'h30, 32'h44);
        expectEvent(1, c+2, 1, 0, 0, 0, 0, 32'h10, 32'h0, 3'b010, 32'h0);
        applyStimulus(1, 1, 0, 32'h10, 32'h0, 1, 1, 32'h30, 32'h44);
        reset[1] = 1'b1;
        applyStimulus(1, 1, 0, 32'h10, 32'h0, 1, 1, 32'h30, 32'h44);
        reset[1] = 1'b0;
        core_req[1] = 1'b0;
        dbg_req[1]  = 1'b0;
        @(negedge clk);
        checkResetState(1, "reset_mid_read");
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);

        // Reset beats a simultaneous request in IDLE.
        c = cyc;
        reset[1] = 1'b1;
        applyStimulus(1, 1, 1, 32'h40, 32'h55, 0, 0, 32'h0, 32'h0);
        reset[1] = 1'b0;
        expectEvent(1, c+1, 1, 0, 0, 0, 1, 32'h40, 32'h55, 3'b010, 32'h0);
        applyStimulus(1, 1, 1, 32'h40, 32'h55, 0, 0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);

        // Final: rdata holds last read word, scoreboard drained.
        @(negedge clk);
        checks++;
        if (core_rdata[0] !== 32'hC0DE0004) begin
            errors++;
            $display("[TB] FAIL inst0 rdata_hold got %h required %h", core_rdata[0], 32'hC0DE0004);
        end
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("[TB] FAIL inst0 missing_events got %0d pending required 0", q0.size());
        end
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("[TB] FAIL inst1 missing_events got %0d pending required 0", q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter READ_LATENCY, default 1, cycles from grant to read data on mem_data_out; legal range 1..4.
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive core grants allowed while dbg_req is pending; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 core_req / core_we  input  1 / 1  core access request / write enable.
REQ-006 core_addr / core_wdata  input  32 / 32  core byte address / store data.
REQ-007 core_funct3  input  3  core access size and sign code, passed through to memory.
REQ-008 core_gnt / core_rvalid  output  1 / 1  core grant pulse / read-data-valid pulse.
REQ-009 core_rdata  output  32  core read data.
REQ-010 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_funct3, dbg_gnt, dbg_rvalid, dbg_rdata  same direction and width as the core_* ports  debug/loader requester.
REQ-011 mem_wren  output  1  memory write enable.
REQ-012 mem_address / mem_data_in  output  32 / 32  memory address / memory store data.
REQ-013 mem_funct3  output  3  memory access code.
REQ-014 mem_data_out  input  32  memory read data.

Function
REQ-015 The block SHALL use FSM states IDLE, READ_WAIT.
- IDLE: may grant.
- Read grant: IDLE -> READ_WAIT.
- READ_WAIT: counts READ_LATENCY cycles, then -> IDLE.
REQ-016 A grant SHALL be one cycle T: gnt=1 to the winner, and mem_address, mem_data_in and mem_funct3 SHALL be driven combinationally from the winner's inputs in T.
REQ-017 mem_wren SHALL equal the winner's we in cycle T only; mem_wren SHALL be 0 in every other cycle.
REQ-018 Outside grant cycles, mem_address, mem_data_in and mem_funct3 SHALL hold the last granted values.
REQ-019 A write SHALL complete in T; the next grant is permitted at T+1.
REQ-020 A read SHALL assert the owner's rvalid for exactly one cycle at T+READ_LATENCY, with owner's rdata = mem_data_out in that cycle.
REQ-021 The next grant is permitted in the same cycle as that rvalid (back-to-back); no grant SHALL occur in earlier READ_WAIT cycles.
REQ-022 At most one access SHALL be outstanding; the owner (core/dbg) SHALL be registered at grant.
REQ-023 Requests SHALL be sampled only in grant-eligible cycles; a requester holds req and its fields stable until gnt.
- Req deasserted before gnt = withdrawn, no access.
REQ-024 Arbitration SHALL be fixed-priority to core, with starvation counter starve_cnt (4 bits).
- Increments on each core grant while dbg_req=1.
- Clears on dbg grant or whenever dbg_req=0.
REQ-025 When both request and starve_cnt==STARVE_LIMIT, dbg SHALL win; otherwise core wins.
REQ-026 A single requester SHALL be granted in the first eligible cycle.
REQ-027 rdata outputs SHALL hold their last value when rvalid=0.
REQ-028 No gnt or rvalid SHALL ever be asserted to both requesters in the same cycle.

Reset
REQ-029 Synchronous reset SHALL force:
- state IDLE, starve_cnt 0, owner core;
- all gnt, rvalid and mem_wren low;
- mem_address, mem_data_in, rdata all 0; mem_funct3 0.
REQ-030 Reset during READ_WAIT SHALL discard the pending read; no rvalid SHALL follow.
REQ-031 Reset SHALL take priority over a simultaneous request.

Structure
REQ-032 Package dmem_arb_pkg SHALL hold:
- arb_state_t (IDLE, READ_WAIT);
- arb_owner_t (OWN_CORE, OWN_DBG);
- the counter width constant.
REQ-033 One combinational sub-module, dmem_arb_pick, SHALL compute the winner from both reqs, starve_cnt and STARVE_LIMIT; the FSM and datapath stay in dmem_arbiter.

Verification
REQ-034 Core write, addr 0x100, data 0xDEADBEEF: core_gnt and mem_wren high one cycle, mem_address=0x100; next-cycle read of 0x100 yields core_rvalid one cycle later with 0xDEADBEEF.
REQ-035 Both requesters hold req continuously: grant order C,C,C,C,D,C,C,C,C,D with STARVE_LIMIT=4.
REQ-036 Back-to-back core reads of 0x0 then 0x4 (READ_LATENCY=1):
- gnt at T and T+1;
- rvalid at T+1 and T+2 with the correct words.
REQ-037 READ_LATENCY=3, dbg read granted at T, core_req raised at T+1:
- core_gnt no earlier than T+3;
- dbg_rvalid at T+3 only.
REQ-038 Reset asserted at T+1 after a read grant at T: no rvalid at any later cycle, all outputs 0, starve_cnt 0.
REQ-039 dbg_req pulses low for one cycle after 3 core grants: starve_cnt clears; dbg waits a further 4 core grants.
